// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate generator, edge counter and x1/x10 auto-ranging
// sequencer for the frequency meter.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | parked (hold=1); edge counter cleared, gate timer preloaded
// GATE   | counting window, GATE_CYCLES clocks, edges counted
// EVAL   | one cycle: choose range, publish result or discard count
// SETTLE | SETTLE_CYCLES clocks after a range change, counter held at 0
module freq_gate_ctrl #(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int HIGH_LIMIT    = 9999,
  parameter int LOW_LIMIT     = 900
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_sig,
  input  logic             auto_en,
  input  logic             manual_range,
  input  logic             hold,
  output logic             range,
  output logic [CNT_W-1:0] result,
  output logic             result_range,
  output logic             overflow,
  output logic             valid
);

  // The single down-counter serves both the gate window and the settle wait.
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  // Limits may exceed the counter range (small CNT_W), so compare wide.
  localparam int CMP_W = CNT_W + 32;
  localparam logic [CMP_W-1:0] HIGH_CMP = CMP_W'(HIGH_LIMIT);
  localparam logic [CMP_W-1:0] LOW_CMP  = CMP_W'(LOW_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    EVAL   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             meas_s1, meas_s2, meas_s3;
  logic             meas_edge;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic             tmr_done;
  logic             cnt_gt_high, cnt_lt_low, cnt_sat;
  logic             target;
  logic             cnt_clr, cnt_inc;
  logic             tmr_load_gate, tmr_load_settle;
  logic             accept, range_chg;

  assign meas_edge   = meas_s2 & ~meas_s3;
  assign tmr_done    = (tmr == '0);
  assign cnt_gt_high = CMP_W'(cnt) > HIGH_CMP;
  assign cnt_lt_low  = CMP_W'(cnt) < LOW_CMP;
  assign cnt_sat     = (cnt == CNT_MAX);

  // Two-flop synchroniser for the asynchronous divider output plus a delay flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_s1 <= 1'b0;
      meas_s2 <= 1'b0;
      meas_s3 <= 1'b0;
    end else begin
      meas_s1 <= meas_sig;
      meas_s2 <= meas_s1;
      meas_s3 <= meas_s2;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, range target and datapath controls.
  always_comb begin
    state_nxt       = state;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    tmr_load_gate   = 1'b0;
    tmr_load_settle = 1'b0;
    accept          = 1'b0;
    range_chg       = 1'b0;

    // Hysteresis: the step-up and step-down thresholds only apply from the opposite range.
    target = range;
    if (!auto_en) begin
      target = manual_range;
    end else if (!range && cnt_gt_high) begin
      target = 1'b1;
    end else if (range && cnt_lt_low) begin
      target = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_clr       = 1'b1;
        tmr_load_gate = 1'b1;
        if (!hold) begin
          state_nxt = GATE;
        end
      end
      GATE: begin
        cnt_inc = meas_edge;
        if (tmr_done) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        cnt_clr = 1'b1;
        if (target != range) begin
          range_chg       = 1'b1;
          tmr_load_settle = 1'b1;
          state_nxt       = SETTLE;
        end else begin
          accept        = 1'b1;
          tmr_load_gate = 1'b1;
          state_nxt     = hold ? IDLE : GATE;
        end
      end
      SETTLE: begin
        cnt_clr = 1'b1;
        if (tmr_done) begin
          tmr_load_gate = 1'b1;
          state_nxt     = GATE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gate/settle down-counter; terminal count 0 marks the last cycle of the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (tmr_load_gate) begin
      tmr <= GATE_LOAD;
    end else if (tmr_load_settle) begin
      tmr <= SETTLE_LOAD;
    end else if (!tmr_done) begin
      tmr <= tmr - 1'b1;
    end
  end

  // Saturating edge counter; an edge on the last gate cycle is still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc && !cnt_sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Divider range drive; only moved from EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range <= 1'b0;
    end else if (range_chg) begin
      range <= target;
    end
  end

  // Published result, held between accepted windows, with a one-cycle valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_range <= 1'b0;
      overflow     <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= accept;
      if (accept) begin
        result       <= cnt;
        result_range <= range;
        overflow     <= cnt_sat | (range & cnt_gt_high);
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: expected results are queued when a
// window is launched and compared whenever the DUT strobes valid.
module tb_freq_gate_ctrl;

  localparam int GATE_CYCLES   = 100;
  localparam int SETTLE_CYCLES = 4;
  localparam int CNT_W         = 16;
  localparam int HIGH_LIMIT    = 20;
  localparam int LOW_LIMIT     = 3;

  logic             clk;
  logic             rst_n;
  logic             meas_sig;
  logic             auto_en;
  logic             manual_range;
  logic             hold;
  logic             range;
  logic [CNT_W-1:0] result;
  logic             result_range;
  logic             overflow;
  logic             valid;

  logic             range2;
  logic [3:0]       result2;
  logic             result_range2;
  logic             overflow2;
  logic             valid2;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [CNT_W-1:0] res;
    logic             rr;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];

  int gen_period;
  int gen_pulses;
  int gen_id;

  freq_gate_ctrl #(
    .GATE_CYCLES  (GATE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W),
    .HIGH_LIMIT   (HIGH_LIMIT),
    .LOW_LIMIT    (LOW_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_sig    (meas_sig),
    .auto_en     (auto_en),
    .manual_range(manual_range),
    .hold        (hold),
    .range       (range),
    .result      (result),
    .result_range(result_range),
    .overflow    (overflow),
    .valid       (valid)
  );

  // Narrow counter instance, free running on manual x10, to exercise saturation.
  freq_gate_ctrl #(
    .GATE_CYCLES  (GATE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (4),
    .HIGH_LIMIT   (HIGH_LIMIT),
    .LOW_LIMIT    (LOW_LIMIT)
  ) dut_w4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_sig    (meas_sig),
    .auto_en     (1'b0),
    .manual_range(1'b1),
    .hold        (1'b0),
    .range       (range2),
    .result      (result2),
    .result_range(result_range2),
    .overflow    (overflow2),
    .valid       (valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Measured-signal generator: period gen_period, gen_pulses pulses (-1 = endless).
  // A new configuration restarts the waveform 2 time units after the next rising clk.
  initial begin
    int cur_id;
    int cur_p;
    int left;
    int ph;
    cur_id   = 0;
    cur_p    = 0;
    left     = 0;
    ph       = 0;
    meas_sig = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_id != cur_id) begin
        cur_id = gen_id;
        cur_p  = gen_period;
        left   = gen_pulses;
        ph     = 0;
      end
      if (cur_p == 0 || left == 0) begin
        meas_sig = 1'b0;
      end else begin
        meas_sig = (ph < cur_p / 2);
        ph++;
        if (ph == cur_p) begin
          ph = 0;
          if (left > 0) left--;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int res, input logic rr, input logic ov);
    exp_t e;
    e.res = CNT_W'(res);
    e.rr  = rr;
    e.ov  = ov;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score any valid strobe against the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed valid=1 result=%0d expected no pulse", result);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("result_range", 32'(result_range), 32'(e.rr));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_gen(input int p, input int n);
    gen_period = p;
    gen_pulses = n;
    gen_id++;
  endtask

  task automatic oneshot();
    hold = 1'b0;
    tick();
    hold = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (valid !== 1'b1 && n < budget);
    n_checks++;
    assert (valid === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed no valid within %0d cycles, expected a pulse", tag, budget);
    end
  endtask

  task automatic wait_valid2(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (valid2 !== 1'b1 && n < budget);
    n_checks++;
    assert (valid2 === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed no valid within %0d cycles, expected a pulse", tag, budget);
    end
  endtask

  task automatic wait_range(input string tag, input logic val, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (range !== val && n < budget);
    n_checks++;
    assert (range === val) else begin
      n_fail++;
      $error("FAIL %s: observed range=%0d after %0d cycles, expected %0d", tag, range, budget, val);
    end
  endtask

  // Called between clock edges: outputs must already be cleared by the async reset.
  task automatic check_zero(input string tag);
    chk({tag, "_range"}, 32'(range), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_result_range"}, 32'(result_range), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  // Hold reset a few cycles, release with a fresh period-10 input and expect 10 edges.
  task automatic post_reset(input string tag);
    set_gen(0, -1);
    auto_en      = 1'b1;
    manual_range = 1'b0;
    hold         = 1'b0;
    idle(4);
    rst_n = 1'b1;
    set_gen(10, -1);
    push(10, 1'b0, 1'b0);
    idle(5);
    hold = 1'b1;
    wait_valid(tag, 200);
    chk({tag, "_range"}, 32'(range), 32'd0);
  endtask

  initial begin
    int n;
    n_checks     = 0;
    n_fail       = 0;
    gen_period   = 0;
    gen_pulses   = -1;
    gen_id       = 0;
    rst_n        = 1'b1;
    hold         = 1'b1;
    auto_en      = 1'b1;
    manual_range = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(3);
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_range", 32'(range), 32'd0);

    // Auto x1, period 10 -> 10 edges
    set_gen(10, -1);
    idle(25);
    push(10, 1'b0, 1'b0);
    oneshot();
    wait_valid("t1_valid", 200);
    chk("t1_range", 32'(range), 32'd0);

    // Exactly HIGH_LIMIT edges on x1 -> no step up
    set_gen(5, -1);
    idle(15);
    push(20, 1'b0, 1'b0);
    oneshot();
    wait_valid("high_eq_valid", 200);
    chk("high_eq_range", 32'(range), 32'd0);

    // 25 edges -> step up, discard, settle, then period 20 on x10 -> 5
    set_gen(4, -1);
    idle(15);
    oneshot();
    wait_range("t2_step_up", 1'b1, 200);
    set_gen(20, -1);
    chk("t2_no_valid", 32'(valid), 32'd0);
    tick();
    push(5, 1'b1, 1'b0);
    wait_valid("t2_valid", 200);
    chk("t2_range", 32'(range), 32'd1);

    // Exactly LOW_LIMIT edges on x10 -> no step down
    set_gen(0, -1);
    idle(10);
    push(3, 1'b1, 1'b0);
    hold = 1'b0;
    set_gen(10, 3);
    tick();
    hold = 1'b1;
    wait_valid("low_eq_valid", 200);
    chk("low_eq_range", 32'(range), 32'd1);

    // 2 edges on x10 -> step down, then 2 on x1
    set_gen(50, -1);
    idle(60);
    oneshot();
    wait_range("t3_step_down", 1'b0, 200);
    chk("t3_no_valid", 32'(valid), 32'd0);
    tick();
    push(2, 1'b0, 1'b0);
    wait_valid("t3_valid", 200);
    chk("t3_range", 32'(range), 32'd0);

    // Manual x10, period 2 -> 50 edges, over HIGH_LIMIT on x10
    auto_en      = 1'b0;
    manual_range = 1'b1;
    set_gen(2, -1);
    idle(10);
    oneshot();
    wait_range("t4_manual_up", 1'b1, 200);
    tick();
    push(50, 1'b1, 1'b1);
    wait_valid("t4_valid", 200);
    chk("t4_range", 32'(range), 32'd1);

    // 4-bit counter saturates at 15
    wait_valid2("w4_first", 250);
    wait_valid2("w4_second", 250);
    chk("w4_result", 32'(result2), 32'd15);
    chk("w4_overflow", 32'(overflow2), 32'd1);
    chk("w4_result_range", 32'(result_range2), 32'd1);

    // hold raised mid-gate: window completes, then stays idle
    push(50, 1'b1, 1'b1);
    hold = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 50) hold = 1'b1;
    end while (valid !== 1'b1 && n < 300);
    chk("t5_latency", 32'(n), 32'd102);
    idle(150);
    chk("t5_range_kept", 32'(range), 32'd1);

    // Async reset during SETTLE
    manual_range = 1'b0;
    oneshot();
    wait_range("t6_settle_entry", 1'b0, 200);
    rst_n = 1'b0;
    #2 check_zero("t6_settle_rst");
    post_reset("t6_settle_post");

    // Async reset mid-gate after a published x10 result
    auto_en      = 1'b0;
    manual_range = 1'b1;
    set_gen(2, -1);
    idle(10);
    oneshot();
    wait_range("t6_gate_up", 1'b1, 200);
    tick();
    push(50, 1'b1, 1'b1);
    wait_valid("t6_gate_pre", 200);
    oneshot();
    idle(40);
    rst_n = 1'b0;
    #2 check_zero("t6_gate_rst");
    post_reset("t6_gate_post");

    idle(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
